m2vidct_sched: RTL and testbench

//  Block-level scheduler for the m2vidct IDCT core in the MPEG-2 decoder.
//  - Accepts one side-info token (enable, coded) per 8x8 block from the VLD side.
//  - Shifts the token through the s2/s3/s4 side-info pipeline and pulses block_start.
//  - Sequences the 32-beat pixel read-out of the s4 block under out-side backpressure.
//  - Inserts bubble blocks on flush to drain the pipeline.

---
 rtl/m2vidct_sched.sv | 215 +++++++++++++++++++++
 tb/tb_m2vidct_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2vidct_sched.sv
// m2vidct_sched
//   Block-level scheduler for the m2vidct IDCT core. It takes one side-info
//   token per 8x8 block, moves it through the s2/s3/s4 side-info pipeline,
//   pulses block_start towards the IDCT and then reads the s4 block out of
//   the IDCT output buffer, PIX_BEATS beats of two pixels each. A flush
//   request inserts empty (bubble) blocks until the pipeline has drained.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   softreset         synchronous reset with the same effect as reset
//   blk_valid/_ready  side-info token handshake; payload blk_enable, blk_coded
//   flush             one-cycle drain request
//   flush_done        one-cycle pulse once the pipeline is empty
//   ready_idct        IDCT can take a new block
//   block_start       one-cycle start pulse to the IDCT
//   s2_*/s3_*         side info of the blocks in the IDCT input/transform stages
//   pixel_coded       coded flag of the block being read out
//   pixel_addr        read-out address into the IDCT output buffer
//   pix_valid/_ready  read-out beat handshake; pix_last marks the final beat
//   dbg_state         current FSM state, for observation only
//
// Handshake semantics (both token and pixel channels): a transfer happens on
// every rising clock edge where valid and ready are both 1. The pixel side
// holds pix_valid and pixel_addr stable until the beat transfers; the token
// side samples blk_enable/blk_coded only on the transfer edge.
module m2vidct_sched #(
  parameter int PIX_BEATS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       softreset,
  input  logic       blk_valid,
  input  logic       blk_enable,
  input  logic       blk_coded,
  output logic       blk_ready,
  input  logic       flush,
  output logic       flush_done,
  input  logic       ready_idct,
  output logic       block_start,
  output logic       s2_enable,
  output logic       s2_coded,
  output logic       s3_enable,
  output logic       s3_coded,
  output logic       pixel_coded,
  output logic [4:0] pixel_addr,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_last,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] READ  = 3'd4;

  localparam logic [4:0] LAST_ADDR = 5'(PIX_BEATS - 1);

  logic [2:0] state_q, state_d;
  logic       blk_ready_q, blk_ready_d;
  logic       in_en_q, in_en_d;
  logic       in_cod_q, in_cod_d;
  logic       s2_en_q, s2_en_d, s2_cod_q, s2_cod_d;
  logic       s3_en_q, s3_en_d, s3_cod_q, s3_cod_d;
  logic       s4_en_q, s4_en_d, s4_cod_q, s4_cod_d;
  logic       flush_pend_q, flush_pend_d;
  logic [4:0] addr_q, addr_d;
  logic       pix_valid_q, pix_valid_d;

  logic in_idle;
  logic accept;
  logic bubble;
  logic beat;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && blk_valid && blk_ready_q;
  // A new token always wins over bubble insertion; bubbles are only needed
  // while s2 or s3 still hold a real block.
  assign bubble     = in_idle && !accept && flush_pend_q && (s2_en_q || s3_en_q);
  assign flush_done = in_idle && !accept && flush_pend_q && !(s2_en_q || s3_en_q);
  assign beat       = pix_valid_q && pix_ready;

  assign blk_ready   = blk_ready_q;
  assign block_start = (state_q == START);
  assign s2_enable   = s2_en_q;
  assign s2_coded    = s2_cod_q;
  assign s3_enable   = s3_en_q;
  assign s3_coded    = s3_cod_q;
  assign pixel_coded = s4_cod_q;
  assign pixel_addr  = addr_q;
  assign pix_valid   = pix_valid_q;
  assign pix_last    = pix_valid_q && (addr_q == LAST_ADDR);
  assign dbg_state   = state_q;

  always_comb begin
    state_d     = state_q;
    in_en_d     = in_en_q;
    in_cod_d    = in_cod_q;
    s2_en_d     = s2_en_q;
    s2_cod_d    = s2_cod_q;
    s3_en_d     = s3_en_q;
    s3_cod_d    = s3_cod_q;
    s4_en_d     = s4_en_q;
    s4_cod_d    = s4_cod_q;
    addr_d      = addr_q;
    pix_valid_d = pix_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          in_en_d  = blk_enable;
          in_cod_d = blk_coded;
          state_d  = SHIFT;
        end else if (bubble) begin
          in_en_d  = 1'b0;
          in_cod_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (ready_idct) begin
          s4_en_d  = s3_en_q;
          s4_cod_d = s3_cod_q;
          s3_en_d  = s2_en_q;
          s3_cod_d = s2_cod_q;
          s2_en_d  = in_en_q;
          s2_cod_d = in_cod_q;
          state_d  = START;
        end
      end
      START: begin
        state_d = HOLD;
      end
      HOLD: begin
        // Empty s4 (bubble or absent block) has nothing to read out.
        state_d = s4_en_q ? READ : IDLE;
      end
      READ: begin
        if (!pix_valid_q) begin
          // First READ cycle covers the IDCT buffer read latency.
          pix_valid_d = 1'b1;
        end else if (beat) begin
          if (addr_q == LAST_ADDR) begin
            pix_valid_d = 1'b0;
            addr_d      = 5'd0;
            // The block has left the pipeline; clearing s4 leaves a drained
            // pipeline all-zero after a flush.
            s4_en_d     = 1'b0;
            s4_cod_d    = 1'b0;
            state_d     = IDLE;
          end else begin
            addr_d = addr_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A flush arriving while one is already pending is absorbed.
  assign flush_pend_d = flush_pend_q ? !flush_done : flush;
  // Registered so that blk_ready stays low through reset and rises one
  // cycle after release.
  assign blk_ready_d  = (state_d == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      blk_ready_q  <= 1'b0;
      in_en_q      <= 1'b0;
      in_cod_q     <= 1'b0;
      s2_en_q      <= 1'b0;
      s2_cod_q     <= 1'b0;
      s3_en_q      <= 1'b0;
      s3_cod_q     <= 1'b0;
      s4_en_q      <= 1'b0;
      s4_cod_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      addr_q       <= 5'd0;
      pix_valid_q  <= 1'b0;
    end else if (softreset) begin
      state_q      <= IDLE;
      blk_ready_q  <= 1'b0;
      in_en_q      <= 1'b0;
      in_cod_q     <= 1'b0;
      s2_en_q      <= 1'b0;
      s2_cod_q     <= 1'b0;
      s3_en_q      <= 1'b0;
      s3_cod_q     <= 1'b0;
      s4_en_q      <= 1'b0;
      s4_cod_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      addr_q       <= 5'd0;
      pix_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_ready_q  <= blk_ready_d;
      in_en_q      <= in_en_d;
      in_cod_q     <= in_cod_d;
      s2_en_q      <= s2_en_d;
      s2_cod_q     <= s2_cod_d;
      s3_en_q      <= s3_en_d;
      s3_cod_q     <= s3_cod_d;
      s4_en_q      <= s4_en_d;
      s4_cod_q     <= s4_cod_d;
      flush_pend_q <= flush_pend_d;
      addr_q       <= addr_d;
      pix_valid_q  <= pix_valid_d;
    end
  end

endmodule

// File: tb/tb_m2vidct_sched.sv
// Bench for m2vidct_sched: directed steps followed by a randomized phase.
// A monitor keeps a block-level model: the k-th block entering the pipeline
// is the accepted token (or a bubble when none is pending), and when block k
// enters, block k-2 is read out if it is enabled.
module tb_m2vidct_sched;

  localparam int W = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, softreset;
  logic       blk_valid, blk_enable, blk_coded, blk_ready;
  logic       flush, flush_done, ready_idct, block_start;
  logic       s2_enable, s2_coded, s3_enable, s3_coded, pixel_coded;
  logic [4:0] pixel_addr;
  logic       pix_valid, pix_ready, pix_last;
  logic [2:0] dbg_state;

  m2vidct_sched dut (
    .clk(clk), .reset(rst), .softreset(softreset),
    .blk_valid(blk_valid), .blk_enable(blk_enable), .blk_coded(blk_coded),
    .blk_ready(blk_ready), .flush(flush), .flush_done(flush_done),
    .ready_idct(ready_idct), .block_start(block_start),
    .s2_enable(s2_enable), .s2_coded(s2_coded),
    .s3_enable(s3_enable), .s3_coded(s3_coded),
    .pixel_coded(pixel_coded), .pixel_addr(pixel_addr),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .dbg_state(dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];     // {coded, addr} of each expected read-out beat
  logic [1:0]   pend_tok;     // accepted token not yet started {en, coded}
  logic         pend_v = 1'b0;
  logic [1:0]   e1 = 2'b00;   // most recently started block
  logic [1:0]   e2 = 2'b00;   // block started before e1
  logic         flush_pend_m = 1'b0;
  logic         prev_stall = 1'b0;
  logic [4:0]   prev_addr = 5'd0;

  always @(negedge clk) begin
    logic [1:0]   ent;
    logic [W-1:0] e;
    #2;
    if (rst || softreset) begin
      exp_q.delete();
      pend_v       = 1'b0;
      e1           = 2'b00;
      e2           = 2'b00;
      flush_pend_m = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("mon_stall_valid", pix_valid, 1'b1);
        chk5("mon_stall_addr", pixel_addr, prev_addr);
      end
      if (pix_valid && pix_ready) begin
        chk1("mon_beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk5("mon_addr", pixel_addr, e[4:0]);
          chk1("mon_coded", pixel_coded, e[5]);
          chk1("mon_last", pix_last, e[4:0] == 5'd31);
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_addr  = pixel_addr;

      if (blk_valid && blk_ready) begin
        chk1("mon_accept_free", pend_v, 1'b0);
        pend_tok = {blk_enable, blk_coded};
        pend_v   = 1'b1;
      end

      if (block_start) begin
        if (!pend_v) chk1("mon_bubble_flush", flush_pend_m, 1'b1);
        ent    = pend_v ? pend_tok : 2'b00;
        pend_v = 1'b0;
        chk1("mon_s2_en", s2_enable, ent[1]);
        chk1("mon_s2_cod", s2_coded, ent[0]);
        chk1("mon_s3_en", s3_enable, e1[1]);
        chk1("mon_s3_cod", s3_coded, e1[0]);
        if (e2[1]) begin
          for (int a = 0; a < 32; a++) exp_q.push_back({e2[0], 5'(a)});
        end
        e2 = e1;
        e1 = ent;
      end

      if (flush_done) begin
        chk1("mon_done_pending", flush_pend_m, 1'b1);
        chk1("mon_done_empty", e1[1] || e2[1], 1'b0);
        flush_pend_m = 1'b0;
      end else if (flush) begin
        flush_pend_m = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offers one token and returns at the start of the cycle after acceptance.
  task automatic send_tok(input logic en, input logic cod);
    int n;
    n = 0;
    @(negedge clk);
    blk_valid = 1'b1; blk_enable = en; blk_coded = cod;
    #3;
    while (!blk_ready && n < 200) begin
      @(negedge clk); #3; n++;
    end
    chk1("tok_accept", blk_ready, 1'b1);
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic do_softreset();
    @(negedge clk);
    softreset = 1'b1; blk_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    softreset = 1'b0;
    #3;
    chk1("srst_blk_ready", blk_ready, 1'b0);
    chk1("srst_s2_en", s2_enable, 1'b0);
    chk5("srst_state", {2'b00, dbg_state}, 5'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   n, beats, cycles, starts, bubbles, dones;
    logic pr, held;

    rst = 1'b1; softreset = 1'b0; blk_valid = 1'b1; blk_enable = 1'b1;
    blk_coded = 1'b1; flush = 1'b0; ready_idct = 1'b1; pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk1("rst_blk_ready", blk_ready, 1'b0);
    chk1("rst_block_start", block_start, 1'b0);
    chk1("rst_s2_en", s2_enable, 1'b0);
    chk1("rst_s3_en", s3_enable, 1'b0);
    chk1("rst_pix_valid", pix_valid, 1'b0);
    chk1("rst_pix_last", pix_last, 1'b0);
    chk1("rst_flush_done", flush_done, 1'b0);
    chk1("rst_pixel_coded", pixel_coded, 1'b0);
    chk5("rst_pixel_addr", pixel_addr, 5'd0);
    chk5("rst_state", {2'b00, dbg_state}, 5'd0);
    @(negedge clk); rst = 1'b0; blk_valid = 1'b0; #3;
    chk1("rel_blk_ready_lag", blk_ready, 1'b0);
    @(negedge clk); #3;
    chk1("rel_blk_ready", blk_ready, 1'b1);

    // Single token: start two cycles after accept, nothing to read.
    send_tok(1'b1, 1'b1);
    #3; chk1("t2_shift_no_start", block_start, 1'b0);
    @(negedge clk); #3;
    chk1("t2_start", block_start, 1'b1);
    chk1("t2_s2_en", s2_enable, 1'b1);
    chk1("t2_s2_cod", s2_coded, 1'b1);
    chk1("t2_s3_en", s3_enable, 1'b0);
    chk1("t2_s3_cod", s3_coded, 1'b0);
    @(negedge clk); #3; chk1("t2_start_pulse", block_start, 1'b0);
    repeat (3) begin @(negedge clk); #3; chk1("t2_no_read", pix_valid, 1'b0); end

    // Three tokens: the third start triggers the read-out of the first.
    do_softreset();
    send_tok(1'b1, 1'b1);
    send_tok(1'b1, 1'b0);
    send_tok(1'b1, 1'b1);
    #3; chk1("t3_shift_no_start", block_start, 1'b0);
    @(negedge clk); #3;
    chk1("t3_start", block_start, 1'b1);
    chk1("t3_s2_cod", s2_coded, 1'b1);
    chk1("t3_s3_en", s3_enable, 1'b1);
    chk1("t3_s3_cod", s3_coded, 1'b0);
    @(negedge clk); #3; chk1("t3_hold_no_valid", pix_valid, 1'b0);
    @(negedge clk); #3;
    chk1("t3_entry_no_valid", pix_valid, 1'b0);
    chk5("t3_entry_addr", pixel_addr, 5'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); #3;
      chk1("t3_valid", pix_valid, 1'b1);
      chk5("t3_addr", pixel_addr, 5'(i));
      chk1("t3_last", pix_last, i == 31);
      chk1("t3_coded", pixel_coded, 1'b1);
    end
    @(negedge clk); #3;
    chk1("t3_after_valid", pix_valid, 1'b0);
    chk5("t3_after_addr", pixel_addr, 5'd0);

    // Alternating pix_ready: every stall cycle holds the beat.
    pix_ready = 1'b0;
    send_tok(1'b1, 1'b0);
    n = 0;
    do begin @(negedge clk); #3; n++; end while (!pix_valid && n < 50);
    chk1("t4_valid_seen", pix_valid, 1'b1);
    cycles = 1; beats = 0; pr = 1'b0;
    while (beats < 32 && cycles < 200) begin
      @(negedge clk); pr = !pr; pix_ready = pr; #3;
      cycles++;
      chk1("t4_valid_held", pix_valid, 1'b1);
      if (pix_valid && pix_ready) begin
        beats++;
        chk1("t4_last", pix_last, beats == 32);
        chk1("t4_coded", pixel_coded, 1'b0);
      end
    end
    chki("t4_cycles", cycles, 64);
    chki("t4_beats", beats, 32);
    @(negedge clk); pix_ready = 1'b1; #3;
    chk1("t4_after_valid", pix_valid, 1'b0);

    // ready_idct low for ten SHIFT cycles delays block_start.
    ready_idct = 1'b0;
    send_tok(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #3; chk1("t5_wait_no_start", block_start, 1'b0);
    end
    @(negedge clk); ready_idct = 1'b1; #3;
    chk1("t5_ready_no_start_yet", block_start, 1'b0);
    @(negedge clk); #3;
    chk1("t5_start", block_start, 1'b1);
    chk1("t5_s2_en", s2_enable, 1'b1);
    chk1("t5_s3_cod", s3_coded, 1'b0);
    n = 0; beats = 0;
    while (beats < 32 && n < 100) begin
      @(negedge clk); #3; n++;
      if (pix_valid && pix_ready) beats++;
    end
    chki("t5_beats", beats, 32);

    // Flush after two tokens: two bubbles drain both real blocks.
    do_softreset();
    send_tok(1'b1, 1'b1);
    send_tok(1'b1, 1'b0);
    flush = 1'b1;
    starts = 0; bubbles = 0; beats = 0; dones = 0; n = 0;
    while (dones == 0 && n < 300) begin
      @(negedge clk); flush = 1'b0; #3; n++;
      if (block_start) begin starts++; if (!s2_enable) bubbles++; end
      if (pix_valid && pix_ready) beats++;
      if (flush_done) dones++;
    end
    repeat (5) begin
      @(negedge clk); #3;
      if (flush_done) dones++;
      if (block_start) starts++;
    end
    chki("t6_starts", starts, 3);
    chki("t6_bubbles", bubbles, 2);
    chki("t6_beats", beats, 64);
    chki("t6_flush_done_once", dones, 1);
    chk1("t6_s2_en", s2_enable, 1'b0);
    chk1("t6_s3_en", s3_enable, 1'b0);
    chk1("t6_s4_coded", pixel_coded, 1'b0);

    // Randomized traffic checked by the monitor model.
    held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!held) begin
        blk_valid  = 1'($urandom_range(0, 1));
        blk_enable = ($urandom_range(0, 3) != 0);
        blk_coded  = 1'($urandom_range(0, 1));
      end
      ready_idct = ($urandom_range(0, 3) != 0);
      pix_ready  = ($urandom_range(0, 4) < 3);
      flush      = ($urandom_range(0, 39) == 0);
      #3;
      held = blk_valid && !blk_ready;
    end
    @(negedge clk); flush = 1'b0; ready_idct = 1'b1; pix_ready = 1'b1; #3;
    held = blk_valid && !blk_ready;
    n = 0;
    while (held && n < 200) begin
      @(negedge clk); #3; held = blk_valid && !blk_ready; n++;
    end
    @(negedge clk); blk_valid = 1'b0; flush = 1'b1; #3;
    dones = flush_done ? 1 : 0;
    n = 0;
    while (dones == 0 && n < 600) begin
      @(negedge clk); flush = 1'b0; #3; n++;
      if (flush_done) dones++;
    end
    chki("t7_drain_done", dones, 1);
    @(negedge clk); flush = 1'b0;
    @(negedge clk); #3;
    chki("t7_exp_empty", exp_q.size(), 0);
    chk1("t7_no_pending", pend_v, 1'b0);

    // Asynchronous reset in the middle of a read-out.
    send_tok(1'b1, 1'b1);
    send_tok(1'b1, 1'b1);
    send_tok(1'b1, 1'b1);
    n = 0;
    do begin @(negedge clk); #3; n++; end while (!pix_valid && n < 50);
    chk1("t8_reading", pix_valid, 1'b1);
    #1; rst = 1'b1; #1;
    chk1("t8_async_valid", pix_valid, 1'b0);
    chk1("t8_async_start", block_start, 1'b0);
    chk1("t8_async_ready", blk_ready, 1'b0);
    chk5("t8_async_addr", pixel_addr, 5'd0);
    chk5("t8_async_state", {2'b00, dbg_state}, 5'd0);
    @(negedge clk); #3;
    @(negedge clk); rst = 1'b0; #3;
    chk1("t8_rel_ready_lag", blk_ready, 1'b0);
    @(negedge clk); #3;
    chk1("t8_rel_ready", blk_ready, 1'b1);
    send_tok(1'b1, 1'b0);
    @(negedge clk); #3;
    chk1("t8_start", block_start, 1'b1);
    chk1("t8_s2_cod", s2_coded, 1'b0);
    chk1("t8_pipe_cleared", s3_enable, 1'b0);
    repeat (4) @(negedge clk);
    #3;
    chk1("t8_no_read", pix_valid, 1'b0);
    chki("t8_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
